// File: rtl/uart_ping_initiator.sv
// -----------------------------------------------------------------------------
// uart_ping_initiator
//
// Host-side initiator for a UART byte-echo loopback. It sends an incrementing
// byte sequence through a UART core's transmit handshake and waits for each
// echo on the core's receive strobe. It then compares the echo with the byte
// that was sent and keeps saturating pass, mismatch and timeout statistics.
//
// Parameters
//   SEED            first byte sent after reset; later bytes are SEED+1, ... (mod 256)
//   TIMEOUT_CYCLES  maximum clk cycles spent waiting for an echo (>= 2)
//   GAP_CYCLES      idle clk cycles between transactions (>= 1)
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   enable         level; 1 = run transactions back-to-back
//   clear          synchronous pulse; zeroes the three counters
//   tx_start       one-cycle "data ready" pulse to the UART core
//   tx_data        byte to transmit, valid while tx_start = 1
//   rx_valid       one-cycle "byte received" pulse from the UART core
//   rx_data        received byte, valid while rx_valid = 1
//   busy           1 whenever the FSM is not idle
//   err_pulse      one-cycle pulse on a mismatch or a timeout
//   last_sent      byte of the most recent transaction
//   last_rcvd      most recent echo captured while waiting
//   pass_count     matching echoes (saturating)
//   err_count      mismatching echoes (saturating)
//   timeout_count  transactions without an echo (saturating)
// -----------------------------------------------------------------------------
module uart_ping_initiator #(
    parameter logic [7:0]  SEED           = 8'h00,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned GAP_CYCLES     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        clear,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        busy,
    output logic        err_pulse,
    output logic [7:0]  last_sent,
    output logic [7:0]  last_rcvd,
    output logic [15:0] pass_count,
    output logic [15:0] err_count,
    output logic [15:0] timeout_count
);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT,
        CHECK,
        GAP
    } state_t;

    // Terminal values of the shared timer in WAIT and GAP.
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] GAP_LAST     = 32'(GAP_CYCLES - 1);

    state_t      state;
    logic [7:0]  seq;
    logic [31:0] timer;
    logic [15:0] passCnt;
    logic [15:0] errCnt;
    logic [15:0] toCnt;

    assign pass_count    = passCnt;
    assign err_count     = errCnt;
    assign timeout_count = toCnt;

    // Saturating increment: statistics stick at 16'hFFFF instead of wrapping.
    function automatic logic [15:0] satInc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            seq       <= SEED;
            timer     <= '0;
            tx_start  <= 1'b0;
            tx_data   <= '0;
            busy      <= 1'b0;
            err_pulse <= 1'b0;
            last_sent <= '0;
            last_rcvd <= '0;
            passCnt   <= '0;
            errCnt    <= '0;
            toCnt     <= '0;
        end else begin
            // Pulses are asserted only by the transition that needs them.
            tx_start  <= 1'b0;
            err_pulse <= 1'b0;

            case (state)
                IDLE: begin
                    if (enable) begin
                        state     <= SEND;
                        tx_start  <= 1'b1;
                        tx_data   <= seq;
                        last_sent <= seq;
                        busy      <= 1'b1;
                    end
                end

                SEND: begin
                    timer <= '0;
                    state <= WAIT;
                end

                // An echo in the timeout cycle takes precedence over the timeout.
                WAIT: begin
                    if (rx_valid) begin
                        last_rcvd <= rx_data;
                        state     <= CHECK;
                    end else if (timer == TIMEOUT_LAST) begin
                        toCnt     <= satInc(toCnt);
                        err_pulse <= 1'b1;
                        seq       <= seq + 8'd1;
                        timer     <= '0;
                        state     <= GAP;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end

                CHECK: begin
                    if (last_rcvd == last_sent) begin
                        passCnt <= satInc(passCnt);
                    end else begin
                        errCnt    <= satInc(errCnt);
                        err_pulse <= 1'b1;
                    end
                    seq   <= seq + 8'd1;
                    timer <= '0;
                    state <= GAP;
                end

                // enable is sampled only here and in IDLE, so dropping it
                // mid-transaction lets the current byte finish cleanly.
                GAP: begin
                    if (timer == GAP_LAST) begin
                        timer <= '0;
                        if (enable) begin
                            state     <= SEND;
                            tx_start  <= 1'b1;
                            tx_data   <= seq;
                            last_sent <= seq;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // Placed last so a clear overrides any increment in the same cycle.
            if (clear) begin
                passCnt <= '0;
                errCnt  <= '0;
                toCnt   <= '0;
            end
        end
    end

endmodule
